// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Used by the main FSM, ALU control and datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    CL_RTYPE,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JUMP,
    CL_ADDI,
    CL_BAD
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_opcode_class.sv
// Opcode to instruction-class decoder.
// Purely combinational; steers DECODE and MEM_ADDR branching.
module mips_opcode_class
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output iclass_e    iclass
);

  always_comb begin
    iclass = CL_BAD;
    unique case (1'b1)
      (opcode == OP_RTYPE): iclass = CL_RTYPE;
      (opcode == OP_LW):    iclass = CL_LOAD;
      (opcode == OP_SW):    iclass = CL_STORE;
      (opcode == OP_BEQ):   iclass = CL_BRANCH;
      (opcode == OP_J):     iclass = CL_JUMP;
      (opcode == OP_ADDI):  iclass = CL_ADDI;
      default:              iclass = CL_BAD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Moore outputs, except FETCH ir_load/pc_write qualified by mem_ready.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_load,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e  r_state;
  state_e  w_next;
  iclass_e w_class;
  logic    r_illegal;
  logic    w_unused_zero;

  // zero gates the PC write in the datapath, not here
  assign w_unused_zero = zero;

  mips_opcode_class u_class (
    .opcode (opcode),
    .iclass (w_class)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   r_illegal <= 1'b0;
    else if (w_next == S_ILLEGAL) r_illegal <= 1'b1;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:     if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        unique case (w_class)
          CL_RTYPE:          w_next = S_EXECUTE;
          CL_LOAD, CL_STORE: w_next = S_MEM_ADDR;
          CL_BRANCH:         w_next = S_BRANCH;
          CL_JUMP:           w_next = S_JUMP;
          CL_ADDI:           w_next = S_ADDI_EXEC;
          default:           w_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:
        w_next = (w_class == CL_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) w_next = S_FETCH;
      S_EXECUTE:   w_next = S_ALU_WB;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      S_ILLEGAL:   w_next = S_ILLEGAL;
      default:     w_next = S_FETCH;
    endcase
  end

  always_comb begin
    ir_load       = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_src        = PC_ALU;
    // held reset keeps every strobe low even though state reads FETCH
    if (reset) begin
      unique case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_load   = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:    alu_src_b = SRCB_IMM_SH;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = PC_ALUOUT;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
        end
        S_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_ADDI_WB:   reg_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign illegal_op = r_illegal;
  assign state      = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed vector table,
// hand-written corner sequences and a random run against a route model.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_load, pc_write, pc_write_cond, iord;
  logic       mem_read, mem_write, mem_to_reg, reg_dst;
  logic       reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  mips_multicycle_control dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .ir_load       (ir_load),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ir, pcw, pcwc, iord, mrd, mwr, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
  } ctl_t;

  typedef struct packed {
    logic [5:0] op;
    logic z, mr;
    logic [3:0] st;
    logic ir, pcw, rw, mwr, pcwc;
  } vec_t;

  ctl_t act;
  assign act = {ir_load, pc_write, pc_write_cond, iord, mem_read,
                mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_src};

  int errors = 0;
  int checks = 0;

  int m_st = 0;
  bit m_ill = 1'b0;
  int path[$];
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  // Control word each step must show, read from the operation table
  function automatic ctl_t exp_ctl(input int st, input logic mr,
                                   input logic rn);
    ctl_t c;
    c = '0;
    if (rn) begin
      case (st)
        0: begin c.mrd = 1; c.asb = 2'b01; c.ir = mr; c.pcw = mr; end
        1: c.asb = 2'b11;
        2: begin c.asa = 1; c.asb = 2'b10; end
        3: begin c.mrd = 1; c.iord = 1; end
        4: begin c.rw = 1; c.m2r = 1; end
        5: begin c.mwr = 1; c.iord = 1; end
        6: begin c.asa = 1; c.aop = 2'b10; end
        7: begin c.rw = 1; c.rdst = 1; end
        8: begin
          c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.psrc = 2'b01;
        end
        9: begin c.pcw = 1; c.psrc = 2'b10; end
        10: begin c.asa = 1; c.asb = 2'b10; end
        11: c.rw = 1;
        default: ;
      endcase
    end
    return c;
  endfunction

  // Steps an instruction walks after DECODE
  function automatic void set_route(input logic [5:0] op);
    path.delete();
    case (op)
      6'h00: begin path.push_back(6); path.push_back(7); end
      6'h23: begin
        path.push_back(2); path.push_back(3); path.push_back(4);
      end
      6'h2B: begin path.push_back(2); path.push_back(5); end
      6'h04: path.push_back(8);
      6'h02: path.push_back(9);
      6'h08: begin path.push_back(10); path.push_back(11); end
      default: path.push_back(12);
    endcase
  endfunction

  function automatic vec_t mk(input logic [5:0] op, input logic z,
                              input logic mr, input logic [3:0] st,
                              input logic ir, input logic pcw,
                              input logic rw, input logic mwr,
                              input logic pcwc);
    vec_t v;
    v = {op, z, mr, st, ir, pcw, rw, mwr, pcwc};
    return v;
  endfunction

  task automatic model_check();
    chk("state", {28'd0, state}, m_st);
    chk("ctl", {16'd0, act}, {16'd0, exp_ctl(m_st, mem_ready, reset)});
    chk("illegal_op", {31'd0, illegal_op}, {31'd0, m_ill});
    chk("exclusive",
        {31'd0, (mem_read & mem_write) | (pc_write & pc_write_cond)}, 0);
  endtask

  task automatic model_step();
    if (m_st == 0) begin
      if (mem_ready) m_st = 1;
    end else if (m_st == 1) begin
      set_route(opcode);
      m_st = path.pop_front();
    end else if ((m_st == 3 || m_st == 5) && !mem_ready) begin
      m_st = m_st;
    end else if (m_st == 12) begin
      m_st = 12;
    end else if (path.size() > 0) begin
      m_st = path.pop_front();
    end else begin
      m_st = 0;
    end
    if (m_st == 12) m_ill = 1'b1;
  endtask

  task automatic apply(input logic [5:0] op, input logic z,
                       input logic mr);
    opcode = op;
    zero = z;
    mem_ready = mr;
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    #1;
    m_st = 0;
    m_ill = 1'b0;
    path.delete();
    model_check();
    @(posedge clk);
    #1;
    model_check();
    reset = 1'b1;
  endtask

  logic [5:0] legal [6];
  int         seq [4];
  int         ill_cnt;
  logic [5:0] rop;

  initial begin
    legal[0] = 6'h00; legal[1] = 6'h23; legal[2] = 6'h2B;
    legal[3] = 6'h04; legal[4] = 6'h02; legal[5] = 6'h08;

    vt.push_back(mk(6'h00, 0, 1, 0, 1, 1, 0, 0, 0));
    vt.push_back(mk(6'h00, 0, 1, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h00, 0, 1, 6, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h00, 0, 1, 7, 0, 0, 1, 0, 0));
    vt.push_back(mk(6'h23, 0, 1, 0, 1, 1, 0, 0, 0));
    vt.push_back(mk(6'h23, 0, 1, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h23, 0, 1, 2, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h23, 0, 0, 3, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h23, 0, 0, 3, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h23, 0, 1, 3, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h23, 0, 1, 4, 0, 0, 1, 0, 0));
    vt.push_back(mk(6'h2B, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h2B, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h2B, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h2B, 0, 1, 0, 1, 1, 0, 0, 0));
    vt.push_back(mk(6'h2B, 0, 1, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h2B, 0, 1, 2, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h2B, 0, 1, 5, 0, 0, 0, 1, 0));
    vt.push_back(mk(6'h04, 1, 1, 0, 1, 1, 0, 0, 0));
    vt.push_back(mk(6'h04, 1, 1, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h04, 1, 1, 8, 0, 0, 0, 0, 1));
    vt.push_back(mk(6'h04, 0, 1, 0, 1, 1, 0, 0, 0));
    vt.push_back(mk(6'h04, 0, 1, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h04, 0, 1, 8, 0, 0, 0, 0, 1));
    vt.push_back(mk(6'h02, 0, 1, 0, 1, 1, 0, 0, 0));
    vt.push_back(mk(6'h02, 0, 1, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h02, 0, 1, 9, 0, 1, 0, 0, 0));
    vt.push_back(mk(6'h08, 0, 1, 0, 1, 1, 0, 0, 0));
    vt.push_back(mk(6'h08, 0, 1, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h08, 0, 1, 10, 0, 0, 0, 0, 0));
    vt.push_back(mk(6'h08, 0, 1, 11, 0, 0, 1, 0, 0));

    #1;
    rst_pulse();

    foreach (vt[i]) begin
      apply(vt[i].op, vt[i].z, vt[i].mr);
      chk($sformatf("vec%0d_state", i), {28'd0, state}, {28'd0, vt[i].st});
      chk($sformatf("vec%0d_ir", i), {31'd0, ir_load}, {31'd0, vt[i].ir});
      chk($sformatf("vec%0d_pcw", i), {31'd0, pc_write}, {31'd0, vt[i].pcw});
      chk($sformatf("vec%0d_rw", i), {31'd0, reg_write}, {31'd0, vt[i].rw});
      chk($sformatf("vec%0d_mwr", i), {31'd0, mem_write},
          {31'd0, vt[i].mwr});
      chk($sformatf("vec%0d_pcwc", i), {31'd0, pc_write_cond},
          {31'd0, vt[i].pcwc});
      adv();
    end

    // Reset dropped in the middle of EXECUTE
    apply(6'h00, 0, 1); adv();
    apply(6'h00, 0, 1); adv();
    apply(6'h00, 0, 1);
    chk("mid_exec_state", {28'd0, state}, 6);
    rst_pulse();
    chk("rst_reg_write", {31'd0, reg_write}, 0);
    chk("rst_mem_read", {31'd0, mem_read}, 0);
    for (int i = 0; i < 4; i++) begin
      apply(6'h00, 0, 1);
      seq[i] = int'(state);
      adv();
    end
    chk("rtype_s0", seq[0], 0);
    chk("rtype_s1", seq[1], 1);
    chk("rtype_s2", seq[2], 6);
    chk("rtype_s3", seq[3], 7);
    apply(6'h00, 0, 1);
    chk("rtype_back", {28'd0, state}, 0);

    // Unknown opcode locks the FSM until reset
    adv();
    apply(6'h3F, 0, 1); adv();
    for (int i = 0; i < 20; i++) begin
      apply(6'($urandom), 1'($urandom), 1'($urandom));
      chk("ill_state", {28'd0, state}, 12);
      chk("ill_flag", {31'd0, illegal_op}, 1);
      adv();
    end
    rst_pulse();
    chk("ill_cleared", {31'd0, illegal_op}, 0);

    rop = 6'h00;
    ill_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if (m_st == 12) ill_cnt++;
      else ill_cnt = 0;
      if (ill_cnt > 3 || $urandom_range(299) == 0) begin
        rst_pulse();
        ill_cnt = 0;
      end
      if (m_st == 0) begin
        if ($urandom_range(39) == 0) rop = 6'h3F;
        else rop = legal[$urandom_range(5)];
      end
      apply(rop, 1'($urandom), $urandom_range(9) < 7);
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
